// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared ASCON types and constants
package ascon_pack;

   // Permutation state: five 64-bit lanes, lane 0 at index 0
   typedef logic [4:0][63:0] type_state;

   localparam int TAG_WORDS  = 4;
   localparam int TAG_WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      COMPARE = 2'd2
   } type_tag_vfy_fsm;

endpackage

// File: rtl/tag_word_collector.sv
// rtl/tag_word_collector.sv - buffers the four expected-tag beats in arrival order
module tag_word_collector
   import ascon_pack::*;
(
   input  logic                                   clock_i,
   input  logic                                   reset_i,
   input  logic                                   enable_i,
   input  logic                                   clear_i,
   input  logic [TAG_WORD_W-1:0]                  word_i,
   input  logic                                   valid_i,
   output logic                                   ready_o,
   output logic [2:0]                             count_o,
   output logic [TAG_WORDS-1:0][TAG_WORD_W-1:0]   words_o
);

   logic [2:0]                           count_q;
   logic [TAG_WORDS-1:0][TAG_WORD_W-1:0] words_q;

   // Ready only while collecting and the buffer still has room
   always_comb begin
      ready_o = enable_i && (count_q < 3'(TAG_WORDS));
   end

   // Store each accepted beat at the slot given by the running count
   always_ff @(posedge clock_i) begin
      if (reset_i || clear_i) begin
         count_q <= '0;
         words_q <= '0;
      end else if (ready_o && valid_i) begin
         words_q[count_q[1:0]] <= word_i;
         count_q               <= count_q + 3'd1;
      end
   end

   assign count_o = count_q;
   assign words_o = words_q;

endmodule

// File: rtl/ascon_tag_verify.sv
// rtl/ascon_tag_verify.sv - constant-time tag check; ASCON_TAG_MISMATCH_MASK_EN adds per-beat debug mask
module ascon_tag_verify
   import ascon_pack::*;
(
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic                  en_tag_i,
   input  type_state             state_i,
   input  logic [TAG_WORD_W-1:0] tag_word_i,
   input  logic                  tag_valid_i,
   output logic                  tag_ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  tag_ok_o
`ifdef ASCON_TAG_MISMATCH_MASK_EN
   ,
   output logic [TAG_WORDS-1:0]  mismatch_mask_o
`endif
);

   type_tag_vfy_fsm                      fsm_q;
   logic                                 seen_q;
   logic [127:0]                         comp_tag_q;
   logic                                 done_q;
   logic                                 tag_ok_q;
   logic [2:0]                           rx_count;
   logic [TAG_WORDS-1:0][TAG_WORD_W-1:0] rx_words;
   logic [127:0]                         rx_tag;
   logic                                 clear;
   logic                                 accept;
   logic                                 full_next;
   logic                                 diff;
   logic [TAG_WORDS-1:0]                 mask_d;

   // A start outside COMPARE wipes the beat buffer; in COMPARE it is ignored
   assign clear = start_i && (fsm_q != COMPARE);

   tag_word_collector u_collector (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .enable_i (fsm_q == COLLECT),
      .clear_i  (clear),
      .word_i   (tag_word_i),
      .valid_i  (tag_valid_i),
      .ready_o  (tag_ready_o),
      .count_o  (rx_count),
      .words_o  (rx_words)
   );

   // Beat 0 carries the most significant word of the expected tag
   assign rx_tag = {rx_words[0], rx_words[1], rx_words[2], rx_words[3]};

   // Full reduction over every bit so timing never depends on where tags differ
   always_comb begin
      accept    = tag_valid_i && tag_ready_o;
      full_next = (rx_count == 3'd4) || ((rx_count == 3'd3) && accept);
      diff      = |(comp_tag_q ^ rx_tag);
      mask_d    = '0;
      for (int i = 0; i < TAG_WORDS; i++) begin
         mask_d[i] = |(comp_tag_q[127-32*i -: 32] ^ rx_words[i]);
      end
   end

   // Control FSM plus computed-tag capture and verdict registers
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_q      <= IDLE;
         seen_q     <= 1'b0;
         comp_tag_q <= '0;
         done_q     <= 1'b0;
         tag_ok_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            IDLE: begin
               if (start_i) begin
                  fsm_q      <= COLLECT;
                  seen_q     <= 1'b0;
                  comp_tag_q <= '0;
                  tag_ok_q   <= 1'b0;
               end
            end
            COLLECT: begin
               if (start_i) begin
                  seen_q     <= 1'b0;
                  comp_tag_q <= '0;
               end else begin
                  if (en_tag_i) begin
                     comp_tag_q <= {state_i[3], state_i[4]};
                     seen_q     <= 1'b1;
                  end
                  if (full_next && (seen_q || en_tag_i)) begin
                     fsm_q <= COMPARE;
                  end
               end
            end
            COMPARE: begin
               tag_ok_q <= ~diff;
               done_q   <= 1'b1;
               fsm_q    <= IDLE;
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign busy_o   = (fsm_q != IDLE);
   assign done_o   = done_q;
   assign tag_ok_o = tag_ok_q;

`ifdef ASCON_TAG_MISMATCH_MASK_EN
   logic [TAG_WORDS-1:0] mask_q;

   // Debug mask follows the verdict's clear and update points
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         mask_q <= '0;
      end else if (clear && (fsm_q == IDLE)) begin
         mask_q <= '0;
      end else if (fsm_q == COMPARE) begin
         mask_q <= mask_d;
      end
   end

   assign mismatch_mask_o = mask_q;
`else
   logic unused_mask;
   assign unused_mask = ^mask_d;
`endif

endmodule

// File: tb/tb_ascon_tag_verify.sv
// tb/tb_ascon_tag_verify.sv - directed self-checking bench for ascon_tag_verify
module tb_ascon_tag_verify;
   import ascon_pack::*;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic        en_tag_i = 1'b0;
   type_state   state_i = '0;
   logic [31:0] tag_word_i = '0;
   logic        tag_valid_i = 1'b0;
   logic        tag_ready_o;
   logic        busy_o;
   logic        done_o;
   logic        tag_ok_o;
   logic [3:0]  mismatch_mask_o;

   int errors = 0;
   int checks = 0;

   always #5 clock_i = ~clock_i;

   ascon_tag_verify dut (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .start_i     (start_i),
      .en_tag_i    (en_tag_i),
      .state_i     (state_i),
      .tag_word_i  (tag_word_i),
      .tag_valid_i (tag_valid_i),
      .tag_ready_o (tag_ready_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .tag_ok_o    (tag_ok_o)
`ifdef ASCON_TAG_MISMATCH_MASK_EN
      ,
      .mismatch_mask_o (mismatch_mask_o)
`endif
   );

`ifndef ASCON_TAG_MISMATCH_MASK_EN
   assign mismatch_mask_o = 4'b0000;
`endif

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic do_beat(input logic [31:0] w);
      tag_word_i  = w;
      tag_valid_i = 1'b1;
      tick();
      tag_valid_i = 1'b0;
   endtask

   task automatic do_en();
      en_tag_i = 1'b1;
      tick();
      en_tag_i = 1'b0;
   endtask

   task automatic check_mask(input string tag, input logic [3:0] exp);
`ifdef ASCON_TAG_MISMATCH_MASK_EN
      check(tag, 32'(mismatch_mask_o), 32'(exp));
`endif
   endtask

   // Called right after the edge that sampled the last required event
   task automatic check_verdict(input string tag, input logic exp_ok, input logic [3:0] exp_mask);
      check({tag, "_cmp_done0"}, 32'(done_o), 32'd0);
      check({tag, "_cmp_busy"},  32'(busy_o), 32'd1);
      tick();
      check({tag, "_done"},      32'(done_o), 32'd1);
      check({tag, "_ok"},        32'(tag_ok_o), 32'(exp_ok));
      check({tag, "_idle"},      32'(busy_o), 32'd0);
      check_mask({tag, "_mask"}, exp_mask);
      tick();
      check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
      check({tag, "_ok_held"},    32'(tag_ok_o), 32'(exp_ok));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      state_i[3] = 64'h0123456789ABCDEF;
      state_i[4] = 64'hFEDCBA9876543210;
      tick();
      tick();
      reset_i = 1'b0;
      check("rst_ready", 32'(tag_ready_o), 32'd0);
      check("rst_busy",  32'(busy_o), 32'd0);
      check("rst_done",  32'(done_o), 32'd0);
      check("rst_ok",    32'(tag_ok_o), 32'd0);
      check_mask("rst_mask", 4'b0000);

      // Match, en_tag first
      tag_valid_i = 1'b1;
      tag_word_i  = 32'hDEADBEEF;
      check("idle_ready", 32'(tag_ready_o), 32'd0);
      tag_valid_i = 1'b0;
      do_start();
      check("start_busy",  32'(busy_o), 32'd1);
      check("start_ready", 32'(tag_ready_o), 32'd1);
      do_en();
      do_beat(32'h01234567);
      do_beat(32'h89ABCDEF);
      do_beat(32'hFEDCBA98);
      do_beat(32'h76543210);
      check("match_ready_full", 32'(tag_ready_o), 32'd0);
      check_verdict("match", 1'b1, 4'b0000);

      // Mismatch in the last bit of beat 3
      do_start();
      check("mm_ok_cleared", 32'(tag_ok_o), 32'd0);
      do_en();
      do_beat(32'h01234567);
      do_beat(32'h89ABCDEF);
      do_beat(32'hFEDCBA98);
      do_beat(32'h76543211);
      check_verdict("mismatch", 1'b0, 4'b1000);

      // Beats first, extra beat refused, en_tag three cycles later
      do_start();
      do_beat(32'h01234567);
      do_beat(32'h89ABCDEF);
      do_beat(32'hFEDCBA98);
      do_beat(32'h76543210);
      tag_valid_i = 1'b1;
      tag_word_i  = 32'h55555555;
      check("fifth_ready", 32'(tag_ready_o), 32'd0);
      tick();
      check("wait_done0", 32'(done_o), 32'd0);
      tick();
      tick();
      tag_valid_i = 1'b0;
      check("wait_busy", 32'(busy_o), 32'd1);
      do_en();
      check_verdict("late_en", 1'b1, 4'b0000);

      // en_tag coinciding with beat 3, mismatch in beat 0
      do_start();
      do_beat(32'h01234566);
      do_beat(32'h89ABCDEF);
      do_beat(32'hFEDCBA98);
      en_tag_i = 1'b1;
      do_beat(32'h76543210);
      en_tag_i = 1'b0;
      check_verdict("coincide", 1'b0, 4'b0001);

      // Gaps between beats, repeated en_tag (last wins), back-to-back start
      do_start();
      state_i[3] = 64'h1111111111111111;
      do_en();
      state_i[3] = 64'h0123456789ABCDEF;
      do_beat(32'h01234567);
      tick();
      do_beat(32'h89ABCDEF);
      tick();
      tick();
      do_en();
      do_beat(32'hFEDCBA98);
      tick();
      do_beat(32'h76543210);
      check("gap_cmp_busy", 32'(busy_o), 32'd1);
      tick();
      check("gap_done", 32'(done_o), 32'd1);
      check("gap_ok",   32'(tag_ok_o), 32'd1);
      check_mask("gap_mask", 4'b0000);
      do_start();
      check("b2b_busy",  32'(busy_o), 32'd1);
      check("b2b_ok_clr", 32'(tag_ok_o), 32'd0);

      // Restart during COLLECT after two beats
      do_beat(32'hAAAAAAAA);
      do_beat(32'hBBBBBBBB);
      do_en();
      do_start();
      check("restart_busy",  32'(busy_o), 32'd1);
      check("restart_ready", 32'(tag_ready_o), 32'd1);
      do_beat(32'h01234567);
      do_beat(32'h89ABCDEF);
      do_en();
      do_beat(32'hFEDCBA98);
      tick();
      check("restart_no_done", 32'(done_o), 32'd0);
      check("restart_ready3",  32'(tag_ready_o), 32'd1);
      do_beat(32'h76543210);
      check_verdict("restart", 1'b1, 4'b0000);

      // Reset in the middle of COLLECT
      do_start();
      do_en();
      do_beat(32'h01234567);
      do_beat(32'h89ABCDEF);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("mrst_busy",  32'(busy_o), 32'd0);
      check("mrst_ready", 32'(tag_ready_o), 32'd0);
      check("mrst_ok",    32'(tag_ok_o), 32'd0);
      check("mrst_done",  32'(done_o), 32'd0);
      do_beat(32'h99999999);
      check("mrst_ignored", 32'(busy_o), 32'd0);
      do_start();
      do_beat(32'h01234567);
      do_beat(32'h89ABCDEF);
      do_beat(32'hFEDCBA98);
      check("mrst_no_seen", 32'(done_o), 32'd0);
      do_beat(32'h76543210);
      check("mrst_wait_en", 32'(busy_o), 32'd1);
      do_en();
      check_verdict("after_rst", 1'b1, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ascon_tag_verify.md
# ascon_tag_verify

Decryption-side tag checker for the ASCON core. It captures the computed 128-bit tag from the permutation state at finalization and receives the expected tag as four 32-bit words over a valid/ready stream. It then performs a constant-time, data-independent comparison and reports a single pass/fail verdict. It sits between the finalization stage of the core and the ciphertext/tag input interface, and gates plaintext release.

## Interface
Parameters:
- none; widths come from package constants `TAG_WORDS` (4) and `TAG_WORD_W` (32).

Ports:
- `clock_i`  in  1  single clock; all logic on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin a verification; clears any previous verdict.
- `en_tag_i`  in  1  capture the computed tag from `state_i`.
- `state_i`  in  `type_state` (5×64)  permutation state; computed tag = {`state_i[3]`, `state_i[4]`}.
- `tag_word_i`  in  32  expected-tag word; beat 0 = tag[127:96], beat 3 = tag[31:0].
- `tag_valid_i`  in  1  `tag_word_i` valid.
- `tag_ready_o`  out  1  block accepts a word; a beat transfers when valid & ready.
- `busy_o`  out  1  FSM not in IDLE.
- `done_o`  out  1  one-cycle pulse; verdict valid from this cycle on.
- `tag_ok_o`  out  1  1 = tags equal; held until the next `start_i` or reset.
- `mismatch_mask_o`  out  4  per-beat mismatch flags; present only with the macro (see Configuration).

## Operation
- FSM states: IDLE, COLLECT, COMPARE.
- IDLE: `start_i` moves the FSM to COLLECT. The same edge clears the beat counter, the computed-tag-seen flag, `tag_ok_o` and the mask. `en_tag_i` and beats are ignored (`tag_ready_o`=0).
- COLLECT:
  - `tag_ready_o`=1 while beat count < 4.
  - Each accepted beat is stored at index = count, and the count increments.
  - `en_tag_i` captures `state_i[3]`/`state_i[4]` and sets the seen flag. A repeated `en_tag_i` overwrites; the last one wins.
  - A beat and `en_tag_i` in the same cycle are both taken.
- COLLECT→COMPARE: on the edge where count==4 and seen==1 both become true, including when they become true on the same edge.
- COMPARE: exactly one cycle.
  - diff = OR-reduce(computed XOR received) over all 128 bits, with no early exit.
  - Next edge: `tag_ok_o` ← (diff==0), `done_o` ← 1 for one cycle, FSM ← IDLE.
- `start_i` in COLLECT restarts: the count, the flag and the stored data are cleared, and the FSM stays in COLLECT.
- `start_i` in COMPARE is ignored.
- A beat offered when count==4 is not accepted (`tag_ready_o`=0).
- Reset (any state) drives the FSM to IDLE and clears all storage.

## Timing
- Reset values: `tag_ready_o`=0, `busy_o`=0, `done_o`=0, `tag_ok_o`=0, `mismatch_mask_o`=0.
- `tag_ready_o` and `busy_o` decode combinationally from the FSM state and the count.
- `done_o` and `tag_ok_o` are registered.
- Latency: if the last required event (4th beat or `en_tag_i`) is sampled at edge N, then COMPARE occupies cycle N..N+1, and `done_o`/`tag_ok_o` update at edge N+1. That is 2 edges after the last event is presented.
- Latency is independent of tag data and of the mismatch position.
- Back-to-back operation: `start_i` may be asserted in the cycle `done_o` is high. The FSM is already in IDLE, so the start is accepted.

## Configuration
- `ASCON_TAG_MISMATCH_MASK_EN` defined:
  - `mismatch_mask_o[i]` = OR-reduce(computed word i XOR beat i).
  - Registered on the same edge as `tag_ok_o`; cleared on `start_i` and reset.
  - For debug and characterization only; it leaks position information and must not be enabled in production builds.
- Undefined: port `mismatch_mask_o` and its logic are absent; behaviour is otherwise identical.

## Structure
- `ascon_pack` additions: constants `TAG_WORDS`=4 and `TAG_WORD_W`=32; enum `type_tag_vfy_fsm` {IDLE, COLLECT, COMPARE}. `type_state` already resides there.
- One sub-module, `tag_word_collector`: 2-bit+1 beat counter, 4×32 word buffer, ready generation, clear input. The FSM and the comparator stay in the top module.

## Test plan
- Match: `state_i[3]`=64'h0123456789ABCDEF, `state_i[4]`=64'hFEDCBA9876543210, beats 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210 → `done_o` pulse, `tag_ok_o`=1, mask 4'b0000.
- Mismatch: same as above but beat 3 = 0x76543211 → `tag_ok_o`=0, mask 4'b1000; `done_o` timing identical to the match case.
- Ordering: 4 beats first (the 5th offered beat sees `tag_ready_o`=0), `en_tag_i` 3 cycles later → `done_o` exactly 2 edges after `en_tag_i`. Also run with `en_tag_i` before the beats, and with `en_tag_i` coinciding with beat 3.
- Backpressure/gaps: `tag_valid_i` toggled with idle cycles between beats → all 4 words stored in order, verdict correct.
- Restart: `start_i` during COLLECT after 2 beats → the count restarts at 0; 4 new beats plus `en_tag_i` are required before `done_o`.
- Reset mid-COLLECT after 2 beats → all outputs 0 and FSM in IDLE; beats ignored until `start_i`.
